// File: rtl/multi_timer.sv
// Memory-mapped N-channel timer: per channel TH reload, TL counter, TCON control
// with prescaler/one-shot, W1C overflow flag, and a shared FLAG status word.
module multi_timer #(
    parameter int N_CH    = 2,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8,
    localparam int ADDR_W = $clog2(N_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic [N_CH-1:0]   irq_vec,
    output logic              IRQ
);

    logic [31:0]          ch_idx;
    logic [N_CH-1:0]      flag_vec;
    logic [31:0]          stat_word;
    logic [N_CH:0][31:0]  rd_acc;
    logic                 unused_wd;

    generate
        if (ADDR_W > 2) begin : g_idx
            assign ch_idx = 32'(address[ADDR_W-1:2]);
        end else begin : g_idx_single
            assign ch_idx = '0;
        end
    endgenerate

    assign stat_word = 32'(flag_vec);
    assign rd_acc[0] = '0;
    // Absorbs write_data bits that no register field consumes.
    assign unused_wd = ^write_data;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [WIDTH-1:0]   th_q, th_d, tl_q, tl_d;
        logic [PRESC_W-1:0] presc_q, presc_d, pc_q, pc_d;
        logic               en_q, en_d, ie_q, ie_d, flag_q, flag_d, os_q, os_d;
        logic               sel, wr;
        logic [31:0]        tcon, rd;

        assign sel = (ch_idx == 32'(c));
        assign wr  = MemWrite && sel && (address[1:0] != 2'd3);

        // A bus write to this channel preempts the tick for that cycle.
        always_comb begin
            th_d    = th_q;
            tl_d    = tl_q;
            presc_d = presc_q;
            pc_d    = pc_q;
            en_d    = en_q;
            ie_d    = ie_q;
            flag_d  = flag_q;
            os_d    = os_q;
            if (wr) begin
                case (address[1:0])
                    2'd0: th_d = write_data[WIDTH-1:0];
                    2'd1: tl_d = write_data[WIDTH-1:0];
                    default: begin
                        en_d    = write_data[0];
                        ie_d    = write_data[1];
                        os_d    = write_data[3];
                        presc_d = write_data[8 +: PRESC_W];
                        pc_d    = '0;
                        if (write_data[2]) flag_d = 1'b0;
                    end
                endcase
            end else if (en_q) begin
                if (pc_q == presc_q) begin
                    pc_d = '0;
                    if (tl_q == '1) begin
                        tl_d   = th_q;
                        flag_d = 1'b1;
                        if (os_q) en_d = 1'b0;
                    end else begin
                        tl_d = tl_q + 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end else begin
                pc_d = '0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                th_q    <= '0;
                tl_q    <= '0;
                presc_q <= '0;
                pc_q    <= '0;
                en_q    <= 1'b0;
                ie_q    <= 1'b0;
                flag_q  <= 1'b0;
                os_q    <= 1'b0;
            end else begin
                th_q    <= th_d;
                tl_q    <= tl_d;
                presc_q <= presc_d;
                pc_q    <= pc_d;
                en_q    <= en_d;
                ie_q    <= ie_d;
                flag_q  <= flag_d;
                os_q    <= os_d;
            end
        end

        always_comb begin
            tcon               = '0;
            tcon[0]            = en_q;
            tcon[1]            = ie_q;
            tcon[2]            = flag_q;
            tcon[3]            = os_q;
            tcon[8 +: PRESC_W] = presc_q;
        end

        always_comb begin
            rd = '0;
            if (sel) begin
                case (address[1:0])
                    2'd0:    rd = 32'(th_q);
                    2'd1:    rd = 32'(tl_q);
                    2'd2:    rd = tcon;
                    default: rd = stat_word;
                endcase
            end
        end

        assign rd_acc[c+1] = rd_acc[c] | rd;
        assign flag_vec[c] = flag_q;
        assign irq_vec[c]  = flag_q & ie_q;
    end

    assign read_data = rd_acc[N_CH];
    assign IRQ       = |irq_vec;

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Memory-mapped multi-channel timer peripheral on the CPU data bus. It generalises the single-channel TH/TL/TCON timer to N_CH independent channels with parametrised counter width, a per-channel prescaler, one-shot/auto-reload mode and write-1-to-clear interrupt status. Per-channel interrupts are ORed into one IRQ line to the CPU, and the per-channel vector is also exported.

Parameters:
N_CH, 2, number of independent timer channels (1..8)
WIDTH, 32, counter/reload width in bits (8..32)
PRESC_W, 8, prescaler field/counter width in bits (1..8)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset
MemWrite  input  1  bus write strobe, one cycle per write
address  input  ADDR_W=clog2(N_CH)+2  [1:0] selects register, upper bits select channel (width 2 when N_CH=1)
write_data  input  32  bus write data
read_data  output  32  combinational read data
irq_vec  output  N_CH  per-channel interrupt request
IRQ  output  1  OR of irq_vec

Behaviour:
- Register map per channel c (address[1:0]): 0 = TH reload, 1 = TL counter, 2 = TCON, 3 = STAT.
- TCON bits: [0] EN, [1] IE, [2] FLAG, [3] ONESHOT, [8+:PRESC_W] PRESC. All other bits read 0.
- STAT (read-only, identical in every channel slot): bits [N_CH-1:0] = FLAG of every channel. Writes are ignored.
- read_data is combinational from address. TH/TL are zero-extended from WIDTH to 32. Channel index >= N_CH reads 0 and ignores writes.
- Writes: TH/TL take write_data[WIDTH-1:0]. A TCON write loads EN, IE, ONESHOT and PRESC. FLAG is write-1-to-clear: writing 1 clears it, writing 0 leaves it unchanged.
- Any write to a channel's TH, TL or TCON suppresses that channel's tick/count/reload in that cycle. Other channels keep running.
- A TCON write also clears that channel's prescaler counter to 0.
- Prescaler: an internal counter pc[PRESC_W-1:0], active while EN=1.
  - If pc == PRESC, a tick occurs and pc <= 0; otherwise pc <= pc+1.
  - PRESC=0 gives a tick every cycle. PRESC=k gives one tick every k+1 cycles.
  - EN=0 holds pc at 0.
- On a tick:
  - If TL != all-ones, TL <= TL+1.
  - If TL == all-ones (overflow), TL <= TH and FLAG <= 1 (FLAG is set regardless of IE). If ONESHOT=1, EN <= 0 in the same cycle.
- irq_vec[c] = FLAG[c] & IE[c], combinational. IRQ = |irq_vec.
- A FLAG that is already set stays set on further overflows. There is no overflow counter.
- Reset (reset=0, asynchronous): all TH, TL, TCON and prescaler counters go to 0, so irq_vec=0 and IRQ=0. Reset mid-count discards all state. Operation resumes on the first clk edge after reset deasserts.
- TH == all-ones: every tick overflows, so a flag is set every PRESC+1 cycles.
- Latency: a written value is visible on read_data the cycle after the write edge. FLAG/irq_vec rise in the cycle after the overflow tick edge.

Test Plan:
- Reset, then read all registers of both channels -> all 0; IRQ=0, irq_vec=2'b00.
- ch0: TH=FFFFFFFC, TL=FFFFFFFC, TCON=0x3 -> TL goes FD, FE, FF, then reloads FFFFFFFC on the 4th cycle. FLAG=1, irq_vec=01, IRQ=1; TCON reads 0x7. Write TCON=0x4 (only the W1C bit set) -> FLAG=0 and EN/IE are cleared (TCON reads 0), IRQ=0.
- ch1: PRESC=3, TL=FFFFFFFE, TCON=0x303 -> TL increments every 4 cycles; overflow after 8 cycles, then FLAG set; irq_vec=10. STAT reads 0x2 at both address 3 and address 7.
- ONESHOT: ch0 TCON=0xB, TL=FFFFFFFF, TH=5 -> one tick later TL=5, FLAG=1, EN=0 (TCON reads 0xE); TL stays at 5 for 10 further cycles.
- Simultaneous events: write ch0 TL=0x10 in the cycle ch0 would overflow -> TL=0x10, FLAG unchanged. ch1 still counts that cycle. IE=0 with overflow -> FLAG=1 but IRQ=0.
- Assert reset asynchronously mid-count (between clk edges) -> all outputs 0 immediately. After release, TL holds 0 until re-enabled.
